// File: rtl/tns_pkg.sv
// rtl/tns_pkg.sv - shared constants, word type and digit mapping for the 15-TSV TNS receive path
package tns_pkg;

    localparam int GROUPS  = 5;
    localparam int TSV_W   = 15;
    localparam int DATA_W  = 15;
    localparam int TNS06_C = 16807;

    localparam logic [2:0] PAT_RISE = 3'b100;
    localparam logic [2:0] PAT_FALL = 3'b011;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              viol;
        logic [GROUPS-1:0] viol_grp;
    } rx_word_t;

    // 011 and 100 both carry digit 3; the encoder picks whichever is legal for the group history
    function automatic logic [2:0] tns_digit(input logic [2:0] g);
        if (g == PAT_RISE)
            return 3'd3;
        else if (g < 3'd4)
            return g;
        else
            return g - 3'd1;
    endfunction

endpackage

// File: rtl/TNS_dec_15.sv
// rtl/TNS_dec_15.sv - stateless decoder of a 15-TSV codeword into a radix-7 data word
module TNS_dec_15
    import tns_pkg::*;
(
    input  logic [TSV_W-1:0]  tsv,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] acc;

    always_comb begin
        acc = '0;
        for (int j = GROUPS - 1; j >= 0; j--) begin
            acc = acc * 15'd7 + {12'b0, tns_digit(tsv[3*j +: 3])};
        end
    end

    assign data = acc;

endmodule

// File: rtl/tns_rx_fifo2.sv
// rtl/tns_rx_fifo2.sv - two-entry valid/ready buffer, generic over the stored word type
module tns_rx_fifo2 #(
    parameter type T = logic [7:0]
) (
    input  logic clock,
    input  logic reset,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);

    T           mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // a full buffer still accepts when the head leaves on the same edge
    assign in_ready  = (count != 2'd2) | out_ready;
    assign push      = in_valid & in_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tns_rx_15.sv
// rtl/tns_rx_15.sv - TNS link receiver: capture, 3C1S rule check, decode, buffered output
module tns_rx_15
    import tns_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TSV_W-1:0]  tsv_in,
    input  logic              tsv_valid,
    input  logic              clr_count,
    output logic [DATA_W-1:0] out_data,
    output logic              out_viol,
    output logic [GROUPS-1:0] out_viol_grp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  viol_count,
    output logic              overflow
);

    logic [GROUPS-1:0] hist;
    logic [GROUPS-1:0] s1_hist;
    logic [TSV_W-1:0]  s1_tsv;
    logic              s1_valid;
    logic [GROUPS-1:0] viol_grp;
    logic              viol;
    logic [DATA_W-1:0] dec_data;
    rx_word_t          s2_word;
    rx_word_t          out_word;
    logic              fifo_ready;

    // hist follows the wire regardless of whether the buffer can take the word
    always_ff @(posedge clock) begin
        if (reset) begin
            hist     <= '0;
            s1_hist  <= '0;
            s1_tsv   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= tsv_valid;
            if (tsv_valid) begin
                s1_tsv  <= tsv_in;
                s1_hist <= hist;
                for (int j = 0; j < GROUPS; j++)
                    hist[j] <= tsv_in[3*j+2];
            end
        end
    end

    always_comb begin
        viol_grp = '0;
        for (int j = 0; j < GROUPS; j++) begin
            viol_grp[j] = ((s1_tsv[3*j +: 3] == PAT_RISE) && !s1_hist[j]) ||
                          ((s1_tsv[3*j +: 3] == PAT_FALL) &&  s1_hist[j]);
        end
        viol = |viol_grp;
    end

    TNS_dec_15 u_dec (
        .tsv  (s1_tsv),
        .data (dec_data)
    );

    assign s2_word = '{data: dec_data, viol: viol, viol_grp: viol_grp};

    tns_rx_fifo2 #(.T(rx_word_t)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_data   (s2_word),
        .in_valid  (s1_valid),
        .in_ready  (fifo_ready),
        .out_data  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data     = out_word.data;
    assign out_viol     = out_word.viol;
    assign out_viol_grp = out_word.viol_grp;

    always_ff @(posedge clock) begin
        if (reset || clr_count) begin
            viol_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (s1_valid && viol && (viol_count != '1))
                viol_count <= viol_count + CNT_W'(1);
            if (s1_valid && !fifo_ready)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tns_rx_15.sv
// tb/tb_tns_rx_15.sv - scoreboard bench for tns_rx_15
module tb_tns_rx_15;

    logic        clock;
    logic        reset;
    logic [14:0] tsv_in;
    logic        tsv_valid;
    logic        clr_count;
    logic [14:0] out_data;
    logic        out_viol;
    logic [4:0]  out_viol_grp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] viol_count;
    logic        overflow;

    typedef struct {
        logic [14:0] data;
        logic        viol;
        logic [4:0]  grp;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] mdl_hist;
    int         total;
    int         bad;

    tns_rx_15 dut (
        .clock        (clock),
        .reset        (reset),
        .tsv_in       (tsv_in),
        .tsv_valid    (tsv_valid),
        .clr_count    (clr_count),
        .out_data     (out_data),
        .out_viol     (out_viol),
        .out_viol_grp (out_viol_grp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .viol_count   (viol_count),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] digit_of(input logic [2:0] g);
        case (g)
            3'b000: return 3'd0;
            3'b001: return 3'd1;
            3'b010: return 3'd2;
            3'b011: return 3'd3;
            3'b100: return 3'd3;
            3'b101: return 3'd4;
            3'b110: return 3'd5;
            default: return 3'd6;
        endcase
    endfunction

    function automatic logic [14:0] model_decode(input logic [14:0] code);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int j = 0; j < 5; j++) begin
            v = v + w * int'(digit_of(code[3*j +: 3]));
            w = w * 7;
        end
        return v[14:0];
    endfunction

    function automatic logic [4:0] model_rule(input logic [14:0] code, input logic [4:0] h);
        logic [4:0] m;
        for (int j = 0; j < 5; j++)
            m[j] = (code[3*j +: 3] == 3'b100 && !h[j]) || (code[3*j +: 3] == 3'b011 && h[j]);
        return m;
    endfunction

    function automatic logic [14:0] encode(input int value, input logic [4:0] h);
        logic [14:0] c;
        int v;
        int d;
        v = value;
        for (int j = 0; j < 5; j++) begin
            d = v % 7;
            v = v / 7;
            if (d < 3)       c[3*j +: 3] = 3'(d);
            else if (d == 3) c[3*j +: 3] = h[j] ? 3'b100 : 3'b011;
            else             c[3*j +: 3] = 3'(d + 1);
        end
        return c;
    endfunction

    task automatic drive(input logic [14:0] code, input logic keep, input logic use_data, input int data);
        exp_t e;
        e.grp  = model_rule(code, mdl_hist);
        e.viol = |e.grp;
        e.data = use_data ? data[14:0] : model_decode(code);
        for (int j = 0; j < 5; j++)
            mdl_hist[j] = code[3*j+2];
        if (keep)
            sb.push_back(e);
        tsv_in    = code;
        tsv_valid = 1'b1;
        @(posedge clock); #1;
        tsv_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tsv_valid = 1'b0;
        clr_count = 1'b0;
        tsv_in    = '0;
        cycles(2);
        reset = 1'b0;
        sb.delete();
        mdl_hist = '0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while ((sb.size() != 0 || out_valid) && i < budget) begin
            cycles(1);
            i++;
        end
        cycles(1);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d words still expected after %0d cycles", sb.size(), budget);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got data=%0d viol=%0b grp=%05b, none expected", out_data, out_viol, out_viol_grp);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_data !== e.data || out_viol !== e.viol || out_viol_grp !== e.grp) begin
                    bad++;
                    $display("FAIL word: got data=%0d viol=%0b grp=%05b, want data=%0d viol=%0b grp=%05b",
                             out_data, out_viol, out_viol_grp, e.data, e.viol, e.grp);
                end
            end
        end
    end

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0)      begin bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        total++; if (viol_count !== 16'd0)    begin bad++; $display("FAIL reset_count: got %0d want 0", viol_count); end
        total++; if (overflow !== 1'b0)       begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        total++; if (out_data !== 15'd0)      begin bad++; $display("FAIL reset_data: got %0d want 0", out_data); end
        total++; if (out_viol_grp !== 5'd0)   begin bad++; $display("FAIL reset_grp: got %05b want 0", out_viol_grp); end
    endtask

    task automatic test_single_viol();
        do_reset();
        out_ready = 1'b1;
        drive(15'h0004, 1'b1, 1'b0, 0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_early: got valid=%0b want 0", out_valid); end
        cycles(1);
        total++; if (out_valid !== 1'b1)      begin bad++; $display("FAIL latency_valid: got %0b want 1", out_valid); end
        total++; if (out_viol !== 1'b1)       begin bad++; $display("FAIL single_viol: got %0b want 1", out_viol); end
        total++; if (out_viol_grp !== 5'b00001) begin bad++; $display("FAIL single_grp: got %05b want 00001", out_viol_grp); end
        total++; if (viol_count !== 16'd1)    begin bad++; $display("FAIL single_count: got %0d want 1", viol_count); end
        wait_drain(20);
    endtask

    task automatic test_history();
        do_reset();
        out_ready = 1'b1;
        drive(15'h0004, 1'b1, 1'b0, 0);
        drive(15'h0003, 1'b1, 1'b0, 0);
        wait_drain(20);
        total++; if (viol_count !== 16'd2) begin bad++; $display("FAIL fall_count: got %0d want 2", viol_count); end
        do_reset();
        out_ready = 1'b1;
        drive(15'h0004, 1'b1, 1'b0, 0);
        drive(15'h0000, 1'b1, 1'b0, 0);
        drive(15'h0003, 1'b1, 1'b0, 0);
        wait_drain(20);
        total++; if (viol_count !== 16'd1) begin bad++; $display("FAIL reset_hist_count: got %0d want 1", viol_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        drive(15'h7FFF, 1'b1, 1'b0, 0);
        drive(15'h0000, 1'b1, 1'b0, 0);
        drive(15'h6DB6, 1'b0, 1'b0, 0);
        cycles(2);
        total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL bp_overflow: got %0b want 1", overflow); end
        total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
        total++; if (dut.hist !== 5'h1F)   begin bad++; $display("FAIL bp_hist: got %05b want 11111", dut.hist); end
        cycles(2);
        total++; if (out_data !== 15'd16806) begin bad++; $display("FAIL bp_hold: got %0d want 16806", out_data); end
        out_ready = 1'b1;
        wait_drain(20);
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL bp_drained: got valid=%0b want 0", out_valid); end
    endtask

    task automatic test_loopback();
        int v;
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            v = int'($urandom % 32'd16807);
            drive(encode(v, mdl_hist), 1'b1, 1'b1, v);
            total++;
            if (sb[sb.size()-1].viol !== 1'b0) begin
                bad++;
                $display("FAIL encoder_model: value %0d produced an illegal codeword", v);
            end
            if ($urandom_range(3) == 0)
                cycles(1);
        end
        wait_drain(50);
        total++; if (viol_count !== 16'd0) begin bad++; $display("FAIL loop_count: got %0d want 0", viol_count); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL loop_overflow: got %0b want 0", overflow); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        drive(15'h0004, 1'b1, 1'b0, 0);
        drive(15'h0007, 1'b1, 1'b0, 0);
        drive(15'h0007, 1'b0, 1'b0, 0);
        cycles(2);
        total++; if (viol_count !== 16'd1) begin bad++; $display("FAIL pre_reset_count: got %0d want 1", viol_count); end
        total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL pre_reset_overflow: got %0b want 1", overflow); end
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        sb.delete();
        mdl_hist = '0;
        total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL mid_reset_valid: got %0b want 0", out_valid); end
        total++; if (viol_count !== 16'd0) begin bad++; $display("FAIL mid_reset_count: got %0d want 0", viol_count); end
        total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL mid_reset_overflow: got %0b want 0", overflow); end
        out_ready = 1'b1;
        drive(15'h0004, 1'b1, 1'b0, 0);
        wait_drain(20);
        total++; if (viol_count !== 16'd1) begin bad++; $display("FAIL post_reset_flag: got %0d want 1", viol_count); end
    endtask

    task automatic test_clr_count();
        do_reset();
        out_ready = 1'b1;
        drive(15'h0004, 1'b1, 1'b0, 0);
        clr_count = 1'b1;
        cycles(1);
        clr_count = 1'b0;
        total++; if (viol_count !== 16'd0) begin bad++; $display("FAIL clr_priority: got %0d want 0", viol_count); end
        wait_drain(20);
        total++; if (viol_count !== 16'd0) begin bad++; $display("FAIL clr_after: got %0d want 0", viol_count); end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        tsv_in    = '0;
        tsv_valid = 1'b0;
        clr_count = 1'b0;
        out_ready = 1'b0;
        mdl_hist  = '0;
        test_reset();
        test_single_viol();
        test_history();
        test_back_to_back();
        test_loopback();
        test_reset_mid();
        test_clr_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
